quadra_rr_sched: RTL

- Round-robin scheduler that shares one quadra_top pipeline among NREQ independent requesters.
- Accepts one x per cycle from the requester that wins arbitration and issues it to the datapath.
- Carries the winner's ID through a tag pipeline matched to the datapath latency.
- Returns each y to the requester that issued it.
- Sits between requester blocks and the single quadra_top instance.

---
 rtl/quadra_rr_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/quadra_rr_sched.sv
// Round-robin front end sharing one quadra_top pipeline among NREQ requesters.
// Define QUADRA_RR_SCHED_STATS_EN to add per-requester saturating grant counters.
module quadra_rr_sched #(
   parameter int NREQ = 4,
   parameter int X_W  = 24,
   parameter int Y_W  = 24,
   parameter int LAT  = 3
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                en,
   input  logic [NREQ*X_W-1:0] req_x,
   input  logic [NREQ-1:0]     req_vld,
   output logic [NREQ-1:0]     req_rdy,
   output logic [X_W-1:0]      qx,
   output logic                qx_dv,
   input  logic [Y_W-1:0]      qy,
   input  logic                qy_dv,
   output logic [Y_W-1:0]      rsp_y,
   output logic [NREQ-1:0]     rsp_vld,
   output logic                idle,
   output logic                err
`ifdef QUADRA_RR_SCHED_STATS_EN
   ,
   input  logic                cnt_clr,
   output logic [NREQ*16-1:0]  gnt_cnt
`endif
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]  ptr_r;
   logic [IDW-1:0]  gnt_id_s;
   logic            gnt_found_s;
   logic            xfer_s;
   logic [X_W-1:0]  qx_r;
   logic            qx_dv_r;
   logic [IDW-1:0]  qx_id_r;
   logic [LAT-1:0]  tag_vld_r;
   logic [IDW-1:0]  tag_id_r [LAT];
   logic [Y_W-1:0]  rsp_y_r;
   logic [NREQ-1:0] rsp_vld_r;
   logic            err_r;
   logic            last_vld_s;
   logic [IDW-1:0]  last_id_s;

   // Cyclic search from ptr: the first pending requester at or after ptr wins.
   always_comb begin : arb_p
      int          idx;
      logic [IDW-1:0] cand;
      gnt_found_s = 1'b0;
      gnt_id_s    = '0;
      idx         = 0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end else begin
            idx = idx;
         end
         cand = IDW'(idx);
         if (!gnt_found_s && req_vld[cand]) begin
            gnt_found_s = 1'b1;
            gnt_id_s    = cand;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   assign xfer_s  = en & gnt_found_s;
   assign req_rdy = xfer_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id_s) : '0;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ptr_r   <= '0;
         qx_r    <= '0;
         qx_dv_r <= 1'b0;
         qx_id_r <= '0;
      end else if (xfer_s) begin
         if (gnt_id_s == IDW'(NREQ-1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= gnt_id_s + 1'b1;
         end
         qx_r    <= req_x[gnt_id_s*X_W +: X_W];
         qx_dv_r <= 1'b1;
         qx_id_r <= gnt_id_s;
      end else begin
         ptr_r   <= ptr_r;
         qx_r    <= qx_r;
         qx_dv_r <= 1'b0;
         qx_id_r <= qx_id_r;
      end
   end

   // Tag shift register tracks the datapath; it never stalls, so stage LAT-1 lines up with qy_dv.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tag_vld_r <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_id_r[i] <= '0;
         end
      end else begin
         tag_vld_r[0] <= qx_dv_r;
         tag_id_r[0]  <= qx_id_r;
         for (int i = 1; i < LAT; i++) begin
            tag_vld_r[i] <= tag_vld_r[i-1];
            tag_id_r[i]  <= tag_id_r[i-1];
         end
      end
   end

   assign last_vld_s = tag_vld_r[LAT-1];
   assign last_id_s  = tag_id_r[LAT-1];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rsp_y_r   <= '0;
         rsp_vld_r <= '0;
         err_r     <= 1'b0;
      end else begin
         if (qy_dv && last_vld_s) begin
            rsp_y_r   <= qy;
            rsp_vld_r <= {{(NREQ-1){1'b0}}, 1'b1} << last_id_s;
         end else begin
            rsp_y_r   <= rsp_y_r;
            rsp_vld_r <= '0;
         end
         if (qy_dv != last_vld_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign qx      = qx_r;
   assign qx_dv   = qx_dv_r;
   assign rsp_y   = rsp_y_r;
   assign rsp_vld = rsp_vld_r;
   assign err     = err_r;
   assign idle    = ~(qx_dv_r | (|tag_vld_r) | (|rsp_vld_r));

`ifdef QUADRA_RR_SCHED_STATS_EN
   logic [15:0] cnt_r [NREQ];

   // Clear beats increment; counters stick at 16'hFFFF.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_r[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (cnt_clr) begin
               cnt_r[i] <= 16'h0000;
            end else if (xfer_s && (gnt_id_s == IDW'(i)) && (cnt_r[i] != 16'hFFFF)) begin
               cnt_r[i] <= cnt_r[i] + 16'h0001;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   always_comb begin
      gnt_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_cnt[i*16 +: 16] = cnt_r[i];
      end
   end
`endif
endmodule
